turn_scheduler: RTL
===================

Name: turn_scheduler

Overview:
Sequences the two-player turn flow for the board UI renderer. Accepts a move request (1–3 tiles), computes the active player's target X, and issues a one-cycle pos_valid with active_player and target positions to the render controller. It then waits for the renderer's turn_done, checks for arrival at the flag, and either hands the turn to the other player or declares a winner. It sits between the button/dice front end and ui_render, replacing the ad-hoc pos_valid generation in the test top.

Parameters:
TILE_PX, 60, pixel advance per tile
START_X, 20, initial X of both players after reset
FLAG_X, 620, flag X; positions clamp here; reaching it wins
MAX_STEPS, 3, largest legal move_steps value
TIMEOUT_CYCLES, 4000000, max cycles to wait for turn_done before flagging an error

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
move_req  in  1  single-cycle request to move the current player
move_steps  in  2  tiles to move; sampled with move_req; legal range 1..MAX_STEPS
turn_done  in  1  single-cycle pulse from renderer when the animation completes
pos_valid  out  1  single-cycle strobe; positions and active_player are valid
active_player  out  1  0 = player1, 1 = player2; the player being moved
player1_pos_x  out  10  committed/target X of player1
player2_pos_x  out  10  committed/target X of player2
busy  out  1  high from the accepted request until return to IDLE or GAME_OVER
winner_valid  out  1  level; high in GAME_OVER
winner_id  out  1  player that reached FLAG_X
timeout_err  out  1  sticky; set on a turn_done timeout; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over all logic. It forces:
  - state=IDLE; pos_valid=0; active_player=0
  - player1_pos_x = player2_pos_x = START_X
  - busy=0; winner_valid=0; winner_id=0; timeout_err=0; timeout counter=0
  - This applies equally in the middle of WAIT_DONE.
- FSM states: IDLE, ISSUE, WAIT_DONE, CHECK_WIN, GAME_OVER.
- IDLE:
  - move_req=1 with move_steps in 1..MAX_STEPS: accept. Compute target = pos(active) + move_steps*TILE_PX in 11 bits, clamp to FLAG_X, write into the active player's position register, go to ISSUE.
  - move_steps=0 or >MAX_STEPS: request ignored, stay in IDLE.
- ISSUE: pos_valid=1 for exactly one cycle, then WAIT_DONE. Latency: move_req at edge N gives pos_valid high during cycle N+1. busy=1 from cycle N+1.
- WAIT_DONE:
  - Wait for turn_done. On turn_done go to CHECK_WIN.
  - The timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without turn_done: set timeout_err and go to CHECK_WIN (treat the move as complete).
  - turn_done and the final timeout cycle in the same cycle: turn_done wins, no error.
- CHECK_WIN (1 cycle):
  - pos(active)==FLAG_X: winner_id=active_player, go to GAME_OVER.
  - Otherwise: toggle active_player, go to IDLE.
  - busy drops on entry to IDLE or GAME_OVER.
- GAME_OVER: absorbing. move_req ignored, outputs held, pos_valid=0. Exit only by reset.
- Other cases:
  - move_req outside IDLE: dropped, never queued.
  - turn_done outside WAIT_DONE: ignored.
  - A player already at FLAG_X cannot be moved again, since the game has ended.
- Position outputs are registered and stable whenever pos_valid=0. The non-active player's position never changes during a turn.

Decomposition:
- Package turn_pkg holds:
  - state enum turn_state_e
  - localparams POS_W=10 and PLAYER_P1=1'b0 / PLAYER_P2=1'b1
  - function clamp_target(pos, steps) returning the 10-bit clamped X
- One natural sub-module: turn_timeout_counter (load/clear, count enable, expired flag), instantiated once.

Test Plan:
1. Reset, then idle 10 cycles -> pos1=pos2=20, active_player=0, pos_valid=0, busy=0, winner_valid=0.
2. move_req, steps=1 -> pos_valid exactly 1 cycle, next cycle after req, active_player=0, pos1=80. Inject turn_done 50 cycles later -> two cycles later active_player=1, busy=0.
3. Alternation: P2 steps=2 -> pos2=140. P1 steps=3 -> pos1=260. move_req during WAIT_DONE -> no pos_valid, positions unchanged.
4. Clamp/win: P1 at 560, steps=3 -> pos1=620 (not 740). After turn_done -> winner_valid=1, winner_id=0, later move_req produces no pos_valid.
5. Illegal steps=0 in IDLE -> no pos_valid, busy stays 0. Timeout run with TIMEOUT_CYCLES=16 and no turn_done -> timeout_err=1 after 16 cycles, turn passes to the other player.
6. Reset mid-WAIT_DONE, with pos1=200 -> next cycle state IDLE, pos1=20, timeout_err=0. A subsequent turn_done is ignored.

Source files
------------

// File: rtl/turn_pkg.sv
// turn_pkg: shared FSM states, widths, player ids and the clamped-target helper for turn_scheduler
package turn_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, CHECK_WIN, GAME_OVER} turn_state_e;
  localparam int POS_W = 10;
  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;
  localparam int TILE_PX_D = 60;
  localparam int FLAG_X_D = 620;
  function automatic logic [POS_W-1:0] clamp_target(input logic [POS_W-1:0] pos, input logic [1:0] steps,
                                                   input int tile = TILE_PX_D, input int flag = FLAG_X_D);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + (POS_W+1)'(steps) * (POS_W+1)'(tile);
    return sum > (POS_W+1)'(flag) ? (POS_W)'(flag) : sum[POS_W-1:0];
  endfunction
endpackage

// File: rtl/turn_timeout_counter.sv
// turn_timeout_counter: counts cycles while enabled, saturates at TIMEOUT_CYCLES-1 and flags expiry
// ports: clk, rst_n (sync, active-low), i_clear, i_en, o_expired
module turn_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player turn sequencer; accepts moves, strobes target positions, awaits turn_done, detects win
// ports: clk, rst_n (sync, active-low), move_req/move_steps in, turn_done in;
//        pos_valid, active_player, player1_pos_x, player2_pos_x, busy, winner_valid, winner_id, timeout_err out
module turn_scheduler
  import turn_pkg::*;
#(
  parameter int TILE_PX        = 60,
  parameter int START_X        = 20,
  parameter int FLAG_X         = 620,
  parameter int MAX_STEPS      = 3,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             move_req,
  input  logic [1:0]       move_steps,
  input  logic             turn_done,
  output logic             pos_valid,
  output logic             active_player,
  output logic [POS_W-1:0] player1_pos_x,
  output logic [POS_W-1:0] player2_pos_x,
  output logic             busy,
  output logic             winner_valid,
  output logic             winner_id,
  output logic             timeout_err
);
  turn_state_e      r_state, w_next;
  logic             r_active, r_winner, r_err;
  logic [POS_W-1:0] r_p1, r_p2;
  logic [POS_W-1:0] w_cur_pos, w_target;
  logic             w_legal, w_expired, w_at_flag, w_timeout_hit;
  assign w_cur_pos     = r_active == PLAYER_P2 ? r_p2 : r_p1;
  assign w_target      = clamp_target(w_cur_pos, move_steps, TILE_PX, FLAG_X);
  assign w_legal       = move_req && move_steps != 2'd0 && int'(move_steps) <= MAX_STEPS;
  assign w_at_flag     = w_cur_pos == POS_W'(FLAG_X);
  // turn_done on the last permitted cycle beats the timeout
  assign w_timeout_hit = r_state == WAIT_DONE && w_expired && !turn_done;
  turn_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != WAIT_DONE),
    .i_en     (r_state == WAIT_DONE),
    .o_expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_legal ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = (turn_done || w_expired) ? CHECK_WIN : WAIT_DONE;
      CHECK_WIN: w_next = w_at_flag ? GAME_OVER : IDLE;
      default:   w_next = GAME_OVER;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= PLAYER_P1;
      r_p1     <= POS_W'(START_X);
      r_p2     <= POS_W'(START_X);
      r_winner <= PLAYER_P1;
      r_err    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_legal) begin
        if (r_active == PLAYER_P2) r_p2 <= w_target;
        else r_p1 <= w_target;
      end
      if (w_timeout_hit) r_err <= 1'b1;
      if (r_state == CHECK_WIN) begin
        if (w_at_flag) r_winner <= r_active;
        else r_active <= ~r_active;
      end
    end
  end
  assign pos_valid     = r_state == ISSUE;
  assign busy          = r_state == ISSUE || r_state == WAIT_DONE || r_state == CHECK_WIN;
  assign winner_valid  = r_state == GAME_OVER;
  assign winner_id     = r_winner;
  assign timeout_err   = r_err;
  assign active_player = r_active;
  assign player1_pos_x = r_p1;
  assign player2_pos_x = r_p2;
endmodule
